// File: rtl/pc_unit.sv
// Program counter with absolute load, relative branch and increment.
// Latency: one clk_2 falling edge per command; a page-crossing relative branch takes one extra fixup edge.
// Backpressure: busy is high during the fixup edge, and all commands are ignored while it is high.
//
// Ports:
//   clk_2        phase-2 clock; all state changes on its falling edge
//   rst          asynchronous active-high reset
//   data_bus     byte for the low latch, the absolute high byte or the signed relative offset
//   lower_byte   capture data_bus into the low-byte latch
//   branch       pc <= {data_bus, latch}
//   rel_branch   pc <= pc + sign-extended data_bus (low byte first, high byte fixed up next edge)
//   pc_increment pc <= pc + 1
//   pc           current program counter (register output)
//   busy         high while the page-cross fixup edge is pending
//   page_cross   high for the single cycle in which the fixup is pending
module pc_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk_2,
  input  logic        rst,
  input  logic [7:0]  data_bus,
  input  logic        lower_byte,
  input  logic        branch,
  input  logic        rel_branch,
  input  logic        pc_increment,
  output logic [15:0] pc,
  output logic        busy,
  output logic        page_cross
);

  typedef enum logic {
    IDLE  = 1'b0,
    FIXUP = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] low_latch;
  logic       fix_down;   // high byte must be decremented (backward branch) rather than incremented

  // 8-bit add of the offset onto the low byte; bit 8 is the carry out.
  logic [8:0] low_sum;
  logic       crosses;

  assign low_sum = {1'b0, pc[7:0]} + {1'b0, data_bus};
  // A forward offset crosses when it carries; a backward (negative) offset crosses when it does not.
  assign crosses = data_bus[7] ^ low_sum[8];

  always_ff @(negedge clk_2 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      low_latch  <= 8'h00;
      fix_down   <= 1'b0;
      busy       <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (branch) begin
            // The latch keeps its old value even if lower_byte is also asserted.
            pc <= {data_bus, low_latch};
          end else begin
            if (lower_byte) begin
              low_latch <= data_bus;
            end
            if (rel_branch) begin
              pc[7:0] <= low_sum[7:0];
              if (crosses) begin
                state      <= FIXUP;
                fix_down   <= data_bus[7];
                busy       <= 1'b1;
                page_cross <= 1'b1;
              end
            end else if (pc_increment) begin
              pc <= pc + 16'd1;
            end
          end
        end

        FIXUP: begin
          // Commands are deliberately ignored here.
          if (fix_down) begin
            pc[15:8] <= pc[15:8] - 8'd1;
          end else begin
            pc[15:8] <= pc[15:8] + 8'd1;
          end
          state      <= IDLE;
          busy       <= 1'b0;
          page_cross <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          page_cross <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk_2;
  logic        rst;
  logic [7:0]  data_bus;
  logic        lower_byte;
  logic        branch;
  logic        rel_branch;
  logic        pc_increment;
  logic [15:0] pc;
  logic        busy;
  logic        page_cross;

  int checks = 0;
  int errors = 0;

  pc_unit #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk_2        (clk_2),
    .rst          (rst),
    .data_bus     (data_bus),
    .lower_byte   (lower_byte),
    .branch       (branch),
    .rel_branch   (rel_branch),
    .pc_increment (pc_increment),
    .pc           (pc),
    .busy         (busy),
    .page_cross   (page_cross)
  );

  initial begin
    clk_2 = 1'b1;
    forever #5 clk_2 = ~clk_2;
  end

  typedef struct {
    bit          b;
    bit          r;
    bit          i;
    bit          l;
    logic [7:0]  d;
    logic [15:0] exp_pc;
    bit          exp_busy;
    bit          exp_px;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: program counter, latch and pending page fixup target.
  int m_pc;
  int m_latch;
  bit m_pending;
  int m_target;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit b, input bit r, input bit i, input bit l, input logic [7:0] d,
                     input logic [15:0] epc, input bit eb, input bit ep);
    vec_t v;
    v.b = b; v.r = r; v.i = i; v.l = l; v.d = d;
    v.exp_pc = epc; v.exp_busy = eb; v.exp_px = ep;
    vecs.push_back(v);
  endtask

  // Drive commands, let one falling edge happen, then settle before sampling.
  task automatic step(input bit b, input bit r, input bit i, input bit l, input logic [7:0] d);
    branch = b; rel_branch = r; pc_increment = i; lower_byte = l; data_bus = d;
    @(negedge clk_2);
    #1;
    branch = 0; rel_branch = 0; pc_increment = 0; lower_byte = 0;
  endtask

  task automatic load_pc(input logic [15:0] v);
    step(0, 0, 0, 1, v[7:0]);
    step(1, 0, 0, 0, v[15:8]);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    m_pc = 16'hFFFC; m_latch = 0; m_pending = 0; m_target = 0;
  endtask

  // Model: a relative branch reaches (pc + signed offset) mod 2^16, but only the low byte
  // lands on the first edge; if the high byte of the target differs, it lands one edge later.
  task automatic model_step(input bit b, input bit r, input bit i, input bit l, input logic [7:0] d);
    int off;
    int newpc;
    if (m_pending) begin
      m_pc = m_target;
      m_pending = 0;
    end else if (b) begin
      m_pc = (int'(d) << 8) | m_latch;
    end else begin
      if (l) m_latch = int'(d);
      if (r) begin
        off = d[7] ? int'(d) - 256 : int'(d);
        m_target = (m_pc + off) & 32'hFFFF;
        newpc = (m_pc & 32'hFF00) | (m_target & 32'hFF);
        m_pending = (newpc != m_target);
        m_pc = newpc;
      end else if (i) begin
        m_pc = (m_pc + 1) & 32'hFFFF;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    data_bus = 8'h00; lower_byte = 0; branch = 0; rel_branch = 0; pc_increment = 0;

    // Power-on reset.
    #1 rst = 1'b1;
    #1;
    chk("reset_pc", pc, 16'hFFFC);
    chk("reset_busy", busy, 0);
    chk("reset_px", page_cross, 0);
    rst = 1'b0;

    // Directed table, applied in order from the reset state (pc=FFFC, latch=00).
    //   b  r  i  l  data    pc      busy px
    add(0, 0, 0, 1, 8'h00, 16'hFFFC, 0, 0);
    add(1, 0, 0, 0, 8'hC0, 16'hC000, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'hC001, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'hC002, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'hC003, 0, 0);
    add(0, 0, 0, 1, 8'h10, 16'hC003, 0, 0);
    add(1, 1, 1, 1, 8'h80, 16'h8010, 0, 0);  // branch wins, latch keeps 10
    add(1, 0, 0, 0, 8'h80, 16'h8010, 0, 0);  // proves latch unchanged
    add(0, 1, 0, 0, 8'h05, 16'h8015, 0, 0);  // relative, no cross
    add(0, 0, 0, 1, 8'hF0, 16'h8015, 0, 0);
    add(1, 0, 0, 0, 8'h80, 16'h80F0, 0, 0);
    add(0, 1, 0, 0, 8'h20, 16'h8010, 1, 1);  // forward cross
    add(0, 0, 1, 0, 8'h00, 16'h8110, 0, 0);  // fixup, increment ignored
    add(0, 0, 0, 1, 8'h05, 16'h8110, 0, 0);
    add(1, 0, 0, 0, 8'h80, 16'h8005, 0, 0);
    add(0, 1, 0, 0, 8'hF0, 16'h80F5, 1, 1);  // backward cross
    add(1, 1, 1, 1, 8'h33, 16'h7FF5, 0, 0);  // fixup, all commands ignored
    add(1, 0, 0, 0, 8'h12, 16'h1205, 0, 0);  // latch still 05
    add(0, 0, 0, 0, 8'h77, 16'h1205, 0, 0);  // idle hold
    add(0, 0, 0, 1, 8'hFF, 16'h1205, 0, 0);
    add(1, 0, 0, 0, 8'hFF, 16'hFFFF, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 0);  // 16-bit wrap
    add(0, 1, 1, 0, 8'h7F, 16'h007F, 0, 0);  // rel beats increment, +127
    add(0, 1, 0, 0, 8'h80, 16'h00FF, 1, 1);  // -128 crosses backward
    add(0, 0, 0, 0, 8'h00, 16'hFFFF, 0, 0);  // wraps below zero

    foreach (vecs[k]) begin
      step(vecs[k].b, vecs[k].r, vecs[k].i, vecs[k].l, vecs[k].d);
      chk($sformatf("vec%0d_pc", k), pc, vecs[k].exp_pc);
      chk($sformatf("vec%0d_busy", k), busy, vecs[k].exp_busy);
      chk($sformatf("vec%0d_px", k), page_cross, vecs[k].exp_px);
    end

    // Mid-cycle asynchronous reset with no clock edge.
    load_pc(16'h1234);
    chk("pre_rst_pc", pc, 16'h1234);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 16'hFFFC);
    chk("async_rst_busy", busy, 0);
    // Commands across an edge while reset is held are ignored.
    pc_increment = 1; lower_byte = 1; data_bus = 8'hAA;
    @(negedge clk_2);
    #1;
    chk("rst_hold_pc", pc, 16'hFFFC);
    rst = 1'b0;
    step(0, 0, 1, 0, 8'h00);
    chk("post_rst_inc", pc, 16'hFFFD);

    // Reset aborting a fixup.
    load_pc(16'h00F0);
    step(0, 1, 0, 0, 8'h20);
    chk("abort_edge1_pc", pc, 16'h0010);
    chk("abort_edge1_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_pc", pc, 16'hFFFC);
    chk("abort_busy", busy, 0);
    chk("abort_px", page_cross, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 8'h00);
    chk("abort_no_fixup", pc, 16'hFFFC);

    // Randomized run against the model, with occasional reset pulses.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit b, r, i, l;
      logic [7:0] d;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      b = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 3) == 0);
      i = ($urandom_range(0, 1) == 0);
      l = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      model_step(b, r, i, l, d);
      step(b, r, i, l, d);
      chk("rand_pc", pc, m_pc);
      chk("rand_busy", busy, m_pending);
      chk("rand_px", page_cross, m_pending);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
